// File: rtl/aes_top_if.sv
// Host-side bus of the AES-128 core: key/data/control in, result and completion strobe out.
// enable is a level start request sampled only while the core is idle; completedFlag is a one-cycle result-valid strobe with no backpressure.
interface aes_top_if;
   logic [127:0] key;
   logic [127:0] data_in;
   logic         enable;
   logic         ED;
   logic         completedFlag;
   logic [127:0] data_out;

   modport master (output key, data_in, enable, ED, input completedFlag, data_out);
   modport slave  (input key, data_in, enable, ED, output completedFlag, data_out);
endinterface

// File: rtl/aes_top.sv
// Iterative AES-128 encrypt/decrypt core: on-the-fly key expansion into a register file,
// then one cipher round per clock, result written back one cycle after the last round.
module aes_top (
   input  logic       clock,
   input  logic       reset_n,
   aes_top_if.slave   bus,
   output logic [2:0] state_dbg
);
   typedef enum logic [2:0] {IDLE, KEYEXP, INIT, ROUND, DONE} state_t;

   state_t        state, state_nx;
   logic [3:0]    cnt;
   logic [127:0]  rk_file [11];
   logic [127:0]  st;
   logic [127:0]  data_l;
   logic          ed_l;
   logic [127:0]  dout_r;
   logic          done_r;
   logic          ld_start, do_kexp, do_init, do_round, do_wb;
   logic [3:0]    rk_sel;
   logic [127:0]  round_out, kexp_src, rk_next;

   // S-box evaluated from its algebraic definition: GF(2^8) inverse then affine map.
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] sq, acc;
      sq  = a;
      acc = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gmul(sq, sq);
         acc = gmul(acc, sq);
      end
      return acc;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
      logic [15:0] d;
      d = {x, x} << n;
      return d[15:8];
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] b;
      b = ginv(a);
      return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] s);
      return ginv(rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05);
   endfunction

   function automatic logic [7:0] rcon_of(input logic [3:0] i);
      case (i)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [127:0] kexp(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3, t;
      w0 = k[127:96];
      w1 = k[95:64];
      w2 = k[63:32];
      w3 = k[31:0];
      t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
      w0 = w0 ^ t;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   // Byte i sits at bits [127-8i -: 8]; column c holds bytes 4c..4c+3 (row = byte % 4).
   function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] k,
                                              input logic last);
      logic [7:0]   b [16];
      logic [7:0]   t [16];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] o;
      for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) t[r+4*c] = b[r+4*((c+r)%4)];
      if (!last) begin
         for (int c = 0; c < 4; c++) begin
            a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
            t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
         end
      end
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
      return o ^ k;
   endfunction

   function automatic logic [127:0] dec_round(input logic [127:0] s, input logic [127:0] k,
                                              input logic last);
      logic [7:0]   t [16];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) t[r+4*c] = inv_sbox(s[127-8*(r+4*((c-r+4)%4)) -: 8]);
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
      o = o ^ k;
      if (!last) begin
         for (int c = 0; c < 4; c++) begin
            a0 = o[127-32*c -: 8]; a1 = o[119-32*c -: 8];
            a2 = o[111-32*c -: 8]; a3 = o[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09);
            o[119-32*c -: 8] = gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d);
            o[111-32*c -: 8] = gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b);
            o[103-32*c -: 8] = gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e);
         end
      end
      return o;
   endfunction

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   // ROUND runs cnt = 1..10 for the cipher rounds, then cnt = 11 is the write-back cycle.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.enable) state_nx = KEYEXP;
         KEYEXP:  if (cnt == 4'd10) state_nx = INIT;
         INIT:    state_nx = ROUND;
         ROUND:   if (cnt == 4'd11) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      ld_start = (state == IDLE) && bus.enable;
      do_kexp  = (state == KEYEXP);
      do_init  = (state == INIT);
      do_round = (state == ROUND) && (cnt != 4'd11);
      do_wb    = (state == ROUND) && (cnt == 4'd11);
   end

   always_comb begin
      rk_sel = 4'd0;
      if (cnt <= 4'd10) rk_sel = ed_l ? cnt : 4'd10 - cnt;
      round_out = ed_l ? enc_round(st, rk_file[rk_sel], cnt == 4'd10)
                       : dec_round(st, rk_file[rk_sel], cnt == 4'd10);
      kexp_src = rk_file[0];
      if (cnt >= 4'd1 && cnt <= 4'd10) kexp_src = rk_file[cnt - 4'd1];
      rk_next = kexp(kexp_src, rcon_of(cnt));
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt    <= 4'd0;
         st     <= '0;
         data_l <= '0;
         ed_l   <= 1'b0;
         dout_r <= '0;
         done_r <= 1'b0;
         for (int i = 0; i < 11; i++) rk_file[i] <= '0;
      end else begin
         done_r <= do_wb;
         if (ld_start) begin
            rk_file[0] <= bus.key;
            data_l     <= bus.data_in;
            ed_l       <= bus.ED;
            cnt        <= 4'd1;
         end
         if (do_kexp) begin
            rk_file[cnt] <= rk_next;
            cnt          <= (cnt == 4'd10) ? 4'd1 : cnt + 4'd1;
         end
         if (do_init) begin
            st  <= data_l ^ (ed_l ? rk_file[0] : rk_file[10]);
            cnt <= 4'd1;
         end
         if (do_round) begin
            st  <= round_out;
            cnt <= cnt + 4'd1;
         end
         if (do_wb) begin
            dout_r <= st;
            cnt    <= 4'd0;
         end
      end
   end

   assign bus.completedFlag = done_r;
   assign bus.data_out      = dout_r;
   assign state_dbg         = state;
endmodule

// File: tb/tb_aes_top.sv
// Self-checking bench for aes_top: FIPS-197 vectors plus random runs against an
// array-based AES-128 reference model built from the standard's definitions.
module tb_aes_top;
   logic       clk;
   logic       rst_n;
   logic [2:0] state_dbg;
   int         n_checks;
   int         n_errors;
   logic [7:0] sb  [256];
   logic [7:0] isb [256];
   logic [127:0] exp_q [$];

   aes_top_if bus();

   aes_top dut (
      .clock     (clk),
      .reset_n   (rst_n),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // S-box built by walking the multiplicative group with generator 3.
   task automatic build_tables();
      logic [7:0] p, q, x;
      logic       hi;
      p = 8'h01;
      q = 8'h01;
      do begin
         hi = p[7];
         p  = p ^ {p[6:0], 1'b0} ^ (hi ? 8'h1b : 8'h00);
         q  = q ^ {q[6:0], 1'b0};
         q  = q ^ {q[5:0], 2'b0};
         q  = q ^ {q[3:0], 4'b0};
         if (q[7]) q = q ^ 8'h09;
         x  = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
         sb[p] = x ^ 8'h63;
      end while (p != 8'h01);
      sb[0] = 8'h63;
      for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
   endtask

   function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r;
      r = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) r = r ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      end
      return r;
   endfunction

   function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] din,
                                            input logic enc);
      logic [31:0]  w [44];
      logic [7:0]   s [4][4];
      logic [7:0]   t [4][4];
      logic [7:0]   base [4];
      logic [31:0]  tmp;
      logic [7:0]   rc, acc;
      logic [127:0] o;
      int           rnd;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
            rc  = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) s[r][c] = din[127-8*(r+4*c) -: 8];
      if (enc) begin base[0] = 8'h02; base[1] = 8'h03; base[2] = 8'h01; base[3] = 8'h01; end
      else     begin base[0] = 8'h0e; base[1] = 8'h0b; base[2] = 8'h0d; base[3] = 8'h09; end
      rnd = enc ? 0 : 10;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) s[r][c] = s[r][c] ^ w[4*rnd+c][31-8*r -: 8];
      for (int step = 1; step <= 10; step++) begin
         rnd = enc ? step : 10 - step;
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               if (enc) t[r][c] = sb[s[r][(c+r)%4]];
               else     t[r][c] = isb[s[r][(c-r+4)%4]];
         if (!enc)
            for (int r = 0; r < 4; r++)
               for (int c = 0; c < 4; c++) t[r][c] = t[r][c] ^ w[4*rnd+c][31-8*r -: 8];
         if (step < 10) begin
            for (int c = 0; c < 4; c++)
               for (int r = 0; r < 4; r++) begin
                  acc = 8'h00;
                  for (int k = 0; k < 4; k++) acc = acc ^ mul(base[(k-r+4)%4], t[k][c]);
                  s[r][c] = acc;
               end
         end else begin
            for (int r = 0; r < 4; r++)
               for (int c = 0; c < 4; c++) s[r][c] = t[r][c];
         end
         if (enc)
            for (int r = 0; r < 4; r++)
               for (int c = 0; c < 4; c++) s[r][c] = s[r][c] ^ w[4*rnd+c][31-8*r -: 8];
      end
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) o[127-8*(r+4*c) -: 8] = s[r][c];
      return o;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // One run: start edge, then watch 40 cycles for exactly one completion at cycle 22.
   // When change_at > 0, enable stays high until that cycle and inputs are disturbed then.
   task automatic run_op(input logic [127:0] k, input logic [127:0] d, input logic e,
                         input int change_at, input string tag, input logic [127:0] fixed_exp,
                         input logic use_fixed);
      int seen;
      bus.key     = k;
      bus.data_in = d;
      bus.ED      = e;
      bus.enable  = 1'b1;
      exp_q.push_back(use_fixed ? fixed_exp : aes_ref(k, d, e));
      @(negedge clk);
      if (change_at == 0) bus.enable = 1'b0;
      seen = 0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk);
         if (cyc == change_at) begin
            bus.data_in = rand128();
            bus.key     = rand128();
            bus.ED      = ~e;
            bus.enable  = 1'b0;
         end
         if (bus.completedFlag) begin
            seen++;
            if (seen == 1) begin
               check_eq({tag, "_lat"}, 128'(cyc), 128'd22);
               check_eq({tag, "_data"}, bus.data_out, exp_q.pop_front());
            end
         end
      end
      if (seen == 0) void'(exp_q.pop_front());
      check_eq({tag, "_pulses"}, 128'(seen), 128'd1);
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      bus.enable  = 1'b0;
      bus.ED      = 1'b0;
      bus.key     = '0;
      bus.data_in = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

   initial begin
      int          next_exp, seen;
      logic [127:0] rk, rd;
      logic        re;
      n_checks = 0;
      n_errors = 0;
      build_tables();
      do_reset();
      check_eq("reset_data", bus.data_out, '0);
      check_eq("reset_flag", 128'(bus.completedFlag), 128'd0);

      run_op(C1_KEY, C1_PT, 1'b1, 0, "c1_enc", C1_CT, 1'b1);
      run_op(C1_KEY, C1_CT, 1'b0, 0, "c1_dec", C1_PT, 1'b1);
      run_op(B_KEY,  B_PT,  1'b1, 0, "b_enc",  B_CT,  1'b1);

      for (int i = 0; i < 8; i++) begin
         rk = rand128();
         rd = rand128();
         re = 1'($urandom_range(0, 1));
         run_op(rk, rd, re, 0, $sformatf("rand%0d", i), '0, 1'b0);
      end

      // Inputs and ED flipped, enable dropped, all inside ROUND.
      run_op(B_KEY, B_PT, 1'b1, 14, "stable", B_CT, 1'b1);

      // Continuous enable: completions every 24 cycles.
      bus.key     = C1_KEY;
      bus.data_in = C1_CT;
      bus.ED      = 1'b0;
      bus.enable  = 1'b1;
      @(negedge clk);
      next_exp = 22;
      seen     = 0;
      for (int cyc = 1; cyc <= 100; cyc++) begin
         @(negedge clk);
         if (bus.completedFlag) begin
            seen++;
            check_eq("cont_lat", 128'(cyc), 128'(next_exp));
            check_eq("cont_data", bus.data_out, C1_PT);
            next_exp += 24;
         end
      end
      check_eq("cont_count", 128'(seen), 128'd4);
      bus.enable = 1'b0;
      repeat (30) @(negedge clk);

      // Reset abort mid-ROUND.
      bus.key     = B_KEY;
      bus.data_in = B_PT;
      bus.ED      = 1'b1;
      bus.enable  = 1'b1;
      @(negedge clk);
      bus.enable = 1'b0;
      repeat (15) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("abort_data", bus.data_out, '0);
      check_eq("abort_flag", 128'(bus.completedFlag), 128'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         @(negedge clk);
         if (bus.completedFlag) seen++;
      end
      check_eq("abort_noflag", 128'(seen), 128'd0);
      run_op(C1_KEY, C1_PT, 1'b1, 0, "post_abort", C1_CT, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
